// File: rtl/bios_loader.sv
// bios_loader -- stages a byte-wide BIOS download into 16-bit words and
// hands them to a consumer in half-buffer bursts.
//
// Ports:
//   clk_sdr        in   single clock, rising edge
//   reset          in   synchronous, active-high
//   ioctl_download in   download window active
//   ioctl_wr       in   one-cycle byte strobe
//   ioctl_addr     in   byte address of ioctl_dout (25 bits)
//   ioctl_dout     in   download byte
//   bios_req       in   consumer pulls one word per high cycle
//   bios_addr      out  word address of the next word presented (14 bits)
//   bios_din       out  word presented to the consumer (16 bits)
//   bios_wr        out  a burst of BUF_WORDS/2 words is available
//   bios_loaded    out  image complete; holds the CPU out of reset
//   overrun        out  sticky error flag
//   o_state        out  current FSM state, for debug and checkers
//
// Handshake: bios_wr acts as "valid" for a whole half-buffer burst. Every
// cycle bios_req is high while bios_wr is high, one word is consumed:
// bios_din is loaded from the buffer and bios_addr advances, with bios_din
// valid one cycle after the request. The consumer ends the burst by
// dropping bios_req; bios_wr falls in the cycle after that falling edge.
// bios_req seen in any other state has no effect.
module bios_loader #(
    parameter int BUF_WORDS = 64,
    parameter int MAX_BYTES = 32768
) (
    input  logic        clk_sdr,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        bios_req,
    output logic [13:0] bios_addr,
    output logic [15:0] bios_din,
    output logic        bios_wr,
    output logic        bios_loaded,
    output logic        overrun,
    output logic [2:0]  o_state
);

    localparam int AW = $clog2(BUF_WORDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_BURST = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    logic [15:0]     r_buf [BUF_WORDS];
    logic            r_dl_q;
    logic            r_req_q;
    logic [7:0]      r_latch;
    logic            r_latch_vld;
    logic [AW-1:0]   r_latch_idx;
    logic            r_partial;   // bytes written into a half not yet completed
    logic            r_pend;      // a completed half is waiting for its burst
    logic            r_ended;     // download window has closed

    logic            w_dl_rise;
    logic            w_dl_fall;
    logic            w_strobe;
    logic            w_accept;
    logic            w_drop;
    logic            w_half_done;
    logic            w_req_fall;
    logic            w_buf_we;
    logic [AW-1:0]   w_buf_idx;
    logic [15:0]     w_buf_data;

    assign w_dl_rise   = ioctl_download & ~r_dl_q;
    assign w_dl_fall   = ~ioctl_download & r_dl_q;
    assign w_strobe    = ioctl_download & ioctl_wr;
    assign w_accept    = w_strobe & (ioctl_addr < 25'(MAX_BYTES));
    assign w_drop      = w_strobe & ~(ioctl_addr < 25'(MAX_BYTES));
    // An odd byte landing on the last word of a half completes that half.
    assign w_half_done = w_accept & ioctl_addr[0] & (&ioctl_addr[AW-1:1]);
    assign w_req_fall  = r_req_q & ~bios_req;
    assign o_state     = r_state;

    // Buffer write port: odd bytes complete a word; a byte still latched
    // when the window closes is written with a zero upper half.
    always_comb begin
        w_buf_we   = 1'b0;
        w_buf_idx  = ioctl_addr[AW:1];
        w_buf_data = {ioctl_dout, r_latch};
        if (!reset) begin
            if (w_accept && ioctl_addr[0]) begin
                w_buf_we = 1'b1;
            end else if (w_dl_fall && r_latch_vld) begin
                w_buf_we   = 1'b1;
                w_buf_idx  = r_latch_idx;
                w_buf_data = {8'h00, r_latch};
            end
        end
    end

    // Buffer contents deliberately survive reset.
    always_ff @(posedge clk_sdr) begin
        if (w_buf_we) begin
            r_buf[w_buf_idx] <= w_buf_data;
        end
    end

    always_ff @(posedge clk_sdr) begin
        if (reset) begin
            r_state     <= S_IDLE;
            bios_addr   <= '0;
            bios_din    <= '0;
            bios_wr     <= 1'b0;
            bios_loaded <= 1'b0;
            overrun     <= 1'b0;
            // Treat a window that is already open as old, so an interrupted
            // download needs a fresh rising edge to restart.
            r_dl_q      <= 1'b1;
            r_req_q     <= 1'b0;
            r_latch     <= '0;
            r_latch_vld <= 1'b0;
            r_latch_idx <= '0;
            r_partial   <= 1'b0;
            r_pend      <= 1'b0;
            r_ended     <= 1'b0;
        end else begin
            r_dl_q  <= ioctl_download;
            r_req_q <= bios_req;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_dl_rise) begin
                        r_state     <= S_FILL;
                        bios_addr   <= '0;
                        bios_wr     <= 1'b0;
                        bios_loaded <= 1'b0;
                        overrun     <= 1'b0;
                        r_partial   <= 1'b0;
                        r_pend      <= 1'b0;
                        r_ended     <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (r_pend || w_half_done) begin
                        // A deferred half goes first; a half completing in
                        // this same cycle then becomes the deferred one.
                        r_state <= S_BURST;
                        bios_wr <= 1'b1;
                        r_pend  <= r_pend & w_half_done;
                    end else if (r_ended) begin
                        if (r_partial) begin
                            r_state <= S_FLUSH;
                            bios_wr <= 1'b1;
                        end else begin
                            r_state     <= S_DONE;
                            bios_loaded <= 1'b1;
                        end
                    end
                end
                S_BURST, S_FLUSH: begin
                    if (bios_req) begin
                        bios_din  <= r_buf[bios_addr[AW-1:0]];
                        bios_addr <= bios_addr + 14'd1;
                    end
                    if (w_req_fall) begin
                        bios_wr <= 1'b0;
                        if (r_state == S_FLUSH) begin
                            r_state     <= S_DONE;
                            bios_loaded <= 1'b1;
                            r_partial   <= 1'b0;
                        end else begin
                            r_state <= S_FILL;
                        end
                    end
                    if (w_half_done) begin
                        r_pend  <= 1'b1;
                        overrun <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Byte path; placed after the FSM so a byte strobed in the same
            // cycle as the download rising edge is not lost.
            if (w_accept) begin
                if (!ioctl_addr[0]) begin
                    r_latch     <= ioctl_dout;
                    r_latch_vld <= 1'b1;
                    r_latch_idx <= ioctl_addr[AW:1];
                end else begin
                    r_latch_vld <= 1'b0;
                end
            end else if (w_dl_fall) begin
                r_latch_vld <= 1'b0;
            end
            if (w_half_done) begin
                r_partial <= 1'b0;
            end else if (w_accept) begin
                r_partial <= 1'b1;
            end
            if (w_drop) begin
                overrun <= 1'b1;
            end
            if (w_dl_fall) begin
                r_ended <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bios_loader.sv
// Directed bench for bios_loader: streams download images, pulls bursts and
// compares every pulled word against a queue of expected words.
module tb_bios_loader;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic        clk_sdr = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        bios_req;
    logic [13:0] bios_addr;
    logic [15:0] bios_din;
    logic        bios_wr;
    logic        bios_loaded;
    logic        overrun;
    logic [2:0]  o_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_bursts = 0;
    int          b0;
    logic        wr_prev  = 1'b0;
    logic [15:0] exp_q[$];

    bios_loader #(.BUF_WORDS(64), .MAX_BYTES(32768)) dut (
        .clk_sdr        (clk_sdr),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .bios_req       (bios_req),
        .bios_addr      (bios_addr),
        .bios_din       (bios_din),
        .bios_wr        (bios_wr),
        .bios_loaded    (bios_loaded),
        .overrun        (overrun),
        .o_state        (o_state)
    );

    // Clock
    always #5 clk_sdr = ~clk_sdr;

    // Count rising edges of bios_wr (one per burst offered).
    always @(posedge clk_sdr) begin
        wr_prev <= bios_wr;
        if (bios_wr && !wr_prev) n_bursts <= n_bursts + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] bval(input int a, input int seed);
        return 8'(a + seed);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver: one byte per cycle; pushes the expected word on odd bytes.
    task automatic stream(input int start, input int n, input int seed, input bit push);
        for (int i = 0; i < n; i++) begin
            int a;
            a = start + i;
            @(negedge clk_sdr);
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(a);
            ioctl_dout = bval(a, seed);
            if (push && a[0]) exp_q.push_back({bval(a, seed), bval(a - 1, seed)});
        end
        @(negedge clk_sdr);
        ioctl_wr = 1'b0;
    endtask

    task automatic strobe(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk_sdr);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        @(negedge clk_sdr);
        ioctl_wr = 1'b0;
    endtask

    // Scoreboard: pop one expected word and compare with bios_din.
    task automatic check_word(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed word %0h expected nothing (queue empty)", tag, bios_din);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(bios_din), 32'(e));
        end
    endtask

    // Raise bios_req for n cycles; leaves bios_req high with the last word
    // still to be checked (by pull_end or the caller).
    task automatic pull(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_sdr);
            if (i > 0) check_word(tag);
            bios_req = 1'b1;
        end
    endtask

    task automatic pull_end(input string tag);
        @(negedge clk_sdr);
        check_word(tag);
        bios_req = 1'b0;
    endtask

    task automatic wait_wr(input logic lvl, input string tag);
        int k;
        k = 0;
        while (bios_wr !== lvl && k < 300) begin
            @(negedge clk_sdr);
            k++;
        end
        n_checks++;
        assert (bios_wr === lvl) else begin
            n_fail++;
            $error("FAIL %s: bios_wr observed %b expected %b within 300 cycles", tag, bios_wr, lvl);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, 32'(bios_addr), 32'd0);
        chk({tag, "_din"}, 32'(bios_din), 32'd0);
        chk({tag, "_wr"}, 32'(bios_wr), 32'd0);
        chk({tag, "_loaded"}, 32'(bios_loaded), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; bios_req = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_sdr);
        chk_all_zero("reset");
        chk("reset_state", 32'(o_state), 32'(ST_IDLE));
        reset = 1'b0;

        // bios_req in IDLE is ignored
        @(negedge clk_sdr);
        bios_req = 1'b1;
        repeat (4) @(negedge clk_sdr);
        bios_req = 1'b0;
        @(negedge clk_sdr);
        chk("idle_req_addr", 32'(bios_addr), 32'd0);
        chk("idle_req_din", 32'(bios_din), 32'd0);

        // 128 bytes 0x00..0x7F, two bursts of 32 words
        @(negedge clk_sdr); ioctl_download = 1'b1;
        b0 = n_bursts;
        stream(0, 64, 0, 1'b1);
        wait_wr(1'b1, "t1_burst0");
        pull(32, "t1_word"); pull_end("t1_word");
        wait_wr(1'b0, "t1_burst0_end");
        stream(64, 64, 0, 1'b1);
        wait_wr(1'b1, "t1_burst1");
        pull(32, "t1_word"); pull_end("t1_word");
        wait_wr(1'b0, "t1_burst1_end");
        @(negedge clk_sdr); ioctl_download = 1'b0;
        repeat (3) @(negedge clk_sdr);
        chk("t1_bursts", 32'(n_bursts - b0), 32'd2);
        chk("t1_addr", 32'(bios_addr), 32'd64);
        chk("t1_loaded", 32'(bios_loaded), 32'd1);
        chk("t1_state", 32'(o_state), 32'(ST_DONE));
        chk("t1_overrun", 32'(overrun), 32'd0);

        // 69 bytes then window closes: flush burst with dangling byte
        @(negedge clk_sdr); ioctl_download = 1'b1;
        @(negedge clk_sdr);
        chk("t2_loaded_clr", 32'(bios_loaded), 32'd0);
        chk("t2_addr_clr", 32'(bios_addr), 32'd0);
        stream(0, 64, 0, 1'b1);
        wait_wr(1'b1, "t2_burst0");
        pull(32, "t2_word"); pull_end("t2_word");
        wait_wr(1'b0, "t2_burst0_end");
        stream(64, 5, 0, 1'b1);
        exp_q.push_back({8'h00, bval(68, 0)});
        @(negedge clk_sdr); ioctl_download = 1'b0;
        b0 = n_bursts;
        wait_wr(1'b1, "t2_flush");
        chk("t2_loaded_in_flush", 32'(bios_loaded), 32'd0);
        pull(3, "t2_flush_word"); pull_end("t2_flush_word");
        wait_wr(1'b0, "t2_flush_end");
        @(negedge clk_sdr);
        chk("t2_flush_bursts", 32'(n_bursts - b0), 32'd1);
        chk("t2_loaded", 32'(bios_loaded), 32'd1);
        chk("t2_addr", 32'(bios_addr), 32'd35);

        // Out-of-range write is dropped, sets overrun, leaves buffer alone
        @(negedge clk_sdr); ioctl_download = 1'b1;
        stream(0, 63, 0, 1'b1);
        strobe(25'd32768, 8'hAA);
        strobe(25'd32769, 8'hBB);
        chk("t4_overrun", 32'(overrun), 32'd1);
        chk("t4_no_burst", 32'(bios_wr), 32'd0);
        stream(63, 1, 0, 1'b1);
        wait_wr(1'b1, "t4_burst");
        pull(32, "t4_word"); pull_end("t4_word");
        wait_wr(1'b0, "t4_burst_end");
        chk("t4_overrun_sticky", 32'(overrun), 32'd1);
        @(negedge clk_sdr); ioctl_download = 1'b0;
        repeat (3) @(negedge clk_sdr);
        chk("t4_loaded", 32'(bios_loaded), 32'd1);

        // 192 bytes with bios_req low: overrun at byte 128
        @(negedge clk_sdr); ioctl_download = 1'b1;
        @(negedge clk_sdr);
        chk("t3_overrun_clr", 32'(overrun), 32'd0);
        stream(0, 127, 0, 1'b0);
        chk("t3_overrun_127", 32'(overrun), 32'd0);
        chk("t3_wr_127", 32'(bios_wr), 32'd1);
        stream(127, 1, 0, 1'b0);
        chk("t3_overrun_128", 32'(overrun), 32'd1);
        stream(128, 64, 0, 1'b0);
        chk("t3_wr_192", 32'(bios_wr), 32'd1);
        chk("t3_overrun_192", 32'(overrun), 32'd1);
        @(negedge clk_sdr); reset = 1'b1; ioctl_download = 1'b0;
        @(negedge clk_sdr); reset = 1'b0;

        // Reset during a burst at bios_addr=10
        @(negedge clk_sdr); ioctl_download = 1'b1;
        stream(0, 64, 32'h20, 1'b1);
        wait_wr(1'b1, "t5_burst");
        pull(10, "t5_word");
        @(negedge clk_sdr);
        check_word("t5_word");
        chk("t5_addr_at_reset", 32'(bios_addr), 32'd10);
        bios_req = 1'b0; reset = 1'b1;
        @(negedge clk_sdr); reset = 1'b0;
        chk_all_zero("t5_after_reset");
        exp_q.delete();
        repeat (4) @(negedge clk_sdr);
        chk("t5_no_restart", 32'(bios_wr), 32'd0);
        chk("t5_state_idle", 32'(o_state), 32'(ST_IDLE));
        @(negedge clk_sdr); bios_req = 1'b1;
        repeat (3) @(negedge clk_sdr);
        bios_req = 1'b0;
        @(negedge clk_sdr);
        chk("t5_idle_req_addr", 32'(bios_addr), 32'd0);
        chk("t5_idle_req_din", 32'(bios_din), 32'd0);
        ioctl_download = 1'b0;
        @(negedge clk_sdr); ioctl_download = 1'b1;
        stream(0, 64, 32'h80, 1'b1);
        wait_wr(1'b1, "t5_restart_burst");
        chk("t5_restart_addr", 32'(bios_addr), 32'd0);
        pull(32, "t5_restart_word"); pull_end("t5_restart_word");
        wait_wr(1'b0, "t5_restart_end");
        chk("t5_restart_addr_end", 32'(bios_addr), 32'd32);
        @(negedge clk_sdr); ioctl_download = 1'b0;
        repeat (3) @(negedge clk_sdr);
        chk("t5_loaded", 32'(bios_loaded), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bios_loader.md
BIOS_LOADER -- requirements
Module: bios_loader

Interface
REQ-001 SHALL have parameter BUF_WORDS, default 64, meaning staging buffer depth in 16-bit words (power of two, ≥4).
REQ-002 SHALL have parameter MAX_BYTES, default 32768, meaning the largest accepted image size in bytes.
REQ-003 SHALL have port clk_sdr, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ioctl_download, input, 1 bit: download window is active.
REQ-006 SHALL have port ioctl_wr, input, 1 bit: one-cycle byte strobe.
REQ-007 SHALL have port ioctl_addr, input, 25 bits: byte address of ioctl_dout.
REQ-008 SHALL have port ioctl_dout, input, 8 bits: download byte.
REQ-009 SHALL have port bios_req, input, 1 bit: consumer pulls one word per high cycle.
REQ-010 SHALL have port bios_addr, output, 14 bits: word address of the next word presented.
REQ-011 SHALL have port bios_din, output, 16 bits: the word presented to the consumer.
REQ-012 SHALL have port bios_wr, output, 1 bit: a burst of BUF_WORDS/2 words is available.
REQ-013 SHALL have port bios_loaded, output, 1 bit: the image is complete; holds the CPU out of reset.
REQ-014 SHALL have port overrun, output, 1 bit: sticky error flag.

Function
REQ-015 SHALL pack bytes little-endian; an even-address byte is latched; an odd-address byte writes {ioctl_dout, latched} to buf[ioctl_addr[log2(BUF_WORDS):1]].
REQ-016 SHALL accept bytes only when ioctl_download & ioctl_wr, and only for ioctl_addr < MAX_BYTES; a strobe at or above MAX_BYTES is dropped and sets overrun.
REQ-017 SHALL implement states IDLE, FILL, BURST, FLUSH, DONE.
REQ-018 IDLE/DONE → FILL on a rising edge of ioctl_download (registered edge detect); this clears bios_addr, bios_wr, bios_loaded and overrun.
REQ-019 FILL → BURST on the write completing a half (word index low bits all ones); bios_wr=1 from the next cycle.
REQ-020 In BURST, each cycle with bios_req=1 SHALL load bios_din ← buf[bios_addr mod BUF_WORDS] and increment bios_addr by 1, giving 1-cycle latency.
REQ-021 BURST → FILL on the cycle after a falling edge of bios_req (registered bios_req high, current low); bios_wr=0 in that cycle.
REQ-022 Byte writes SHALL continue into the opposite half during BURST.
REQ-023 If a half completes while bios_wr is still high for the previous half, overrun SHALL set; that half's burst is issued after the current one ends.
REQ-024 Falling edge of ioctl_download:
- No partial half pending → DONE.
- Partial half pending → FLUSH.
REQ-025 A dangling even byte at the end SHALL be written as {8'h00, byte}.
REQ-026 FLUSH SHALL behave as BURST (bios_wr=1, pull on bios_req), then → DONE.
REQ-027 Words past the last written word in a flushed half are don't-care.
REQ-028 DONE SHALL set bios_loaded=1 and hold it until reset or the next download rising edge.
REQ-029 bios_req outside BURST/FLUSH SHALL be ignored; bios_addr wraps modulo 2^14.
REQ-030 ioctl_addr restarting at 0 mid-download SHALL be treated as data; no re-synchronisation is performed.

Reset
REQ-031 On reset SHALL set:
- state=IDLE;
- bios_addr=0, bios_din=0, bios_wr=0, bios_loaded=0, overrun=0;
- byte latch cleared.
REQ-032 Reset mid-download SHALL abandon the image; a new rising edge of ioctl_download is required to restart.
REQ-033 Buffer RAM contents SHALL NOT be reset.

Verification
REQ-034 Bench SHALL stream 128 bytes 0x00..0x7F and pulse bios_req 32 cycles per burst, and SHALL check:
- two bursts occur;
- bios_din sequence is 16'h0100, 16'h0302, …, 16'h7F7E;
- bios_addr ends at 64;
- bios_loaded=1 after the download falls.
REQ-035 Bench SHALL stream 69 bytes, then drop ioctl_download, and SHALL check:
- FLUSH burst occurs;
- word 34 = 16'h0044;
- bios_loaded=1 after the burst.
REQ-036 Bench SHALL stream 192 bytes with bios_req held low, and SHALL check:
- overrun=1 at byte 128;
- bios_wr stays 1.
REQ-037 Bench SHALL write at ioctl_addr=32768 and SHALL check:
- the byte is dropped;
- overrun=1;
- buffer is unchanged.
REQ-038 Bench SHALL assert reset during BURST at bios_addr=10, and SHALL check:
- all outputs are 0 on the next cycle;
- a new download starts from bios_addr=0.
REQ-039 Bench SHALL pulse bios_req in IDLE, and SHALL check that bios_addr and bios_din are unchanged.
